// File: rtl/ex_pkg.sv
// Shared types and encodings for the execute stage: ALUOp codes, funct fields,
// decoded ALU operation and multiplier FSM states.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRA = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_SLL,
        ALU_SRA,
        ALU_MUL,
        ALU_NOP
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } ex_state_e;

    // EX/MEM control bits carried alongside the result.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, EX/MEM outputs and the upstream stall of the execute stage.
// master = upstream pipeline driving ID/EX; slave = ex_stage.
interface ex_stage_if;
    logic        valid_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i;
    logic [31:0] Readdata1_i;
    logic [31:0] Readdata2_i;
    logic [31:0] Imm_i;
    logic [9:0]  ALU_i;
    logic [4:0]  INS_11_7_i;

    logic        stall_o;
    logic        valid_o;
    logic        RegWrite_o;
    logic        MemToReg_o;
    logic        MemRead_o;
    logic        MemWrite_o;
    logic [31:0] ALUResult_o;
    logic [31:0] MemWdata_o;
    logic [4:0]  RdAddr_o;

    modport master (
        output valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
        output ALUOp_i, ALUSrc_i, Readdata1_i, Readdata2_i, Imm_i, ALU_i, INS_11_7_i,
        input  stall_o, valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
        input  ALUResult_o, MemWdata_o, RdAddr_o
    );

    modport slave (
        input  valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i,
        input  ALUOp_i, ALUSrc_i, Readdata1_i, Readdata2_i, Imm_i, ALU_i, INS_11_7_i,
        output stall_o, valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o,
        output ALUResult_o, MemWdata_o, RdAddr_o
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative 32-cycle shift-add multiplier, low 32 bits of the product.
// done is high during the last iteration; product then already includes it.
module mul_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    ex_state_e   state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] acc_nxt;

    assign acc_nxt = acc + (mplier[0] ? mcand : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 5'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                        state  <= ST_MUL_BUSY;
                    end
                end
                ST_MUL_BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state == ST_MUL_BUSY);
    assign done    = busy && (cnt == 5'd31);
    assign product = acc_nxt;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, single-cycle ALU, iterative mul and EX/MEM register.
// Latency 1 cycle (mul 33); stall_o holds upstream for the first 32 cycles of a mul.
module ex_stage
    import ex_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    ex_stage_if.slave bus
);

    alu_op_e     op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] alu_res;
    ctrl_t       ctrl_in;

    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;

    logic        valid_q;
    ctrl_t       ctrl_q;
    logic [31:0] result_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    assign f7  = bus.ALU_i[9:3];
    assign f3  = bus.ALU_i[2:0];
    assign opa = bus.Readdata1_i;
    assign opb = bus.ALUSrc_i ? bus.Imm_i : bus.Readdata2_i;

    assign ctrl_in = '{reg_write:  bus.RegWrite_i,
                       mem_to_reg: bus.MemToReg_i,
                       mem_read:   bus.MemRead_i,
                       mem_write:  bus.MemWrite_i};

    always_comb begin
        op = ALU_NOP;
        case (bus.ALUOp_i)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_RTYPE: begin
                case ({f7, f3})
                    {F7_BASE,   F3_ADD}: op = ALU_ADD;
                    {F7_ALT,    F3_ADD}: op = ALU_SUB;
                    {F7_BASE,   F3_AND}: op = ALU_AND;
                    {F7_BASE,   F3_XOR}: op = ALU_XOR;
                    {F7_BASE,   F3_SLL}: op = ALU_SLL;
                    {F7_MULDIV, F3_ADD}: op = ALU_MUL;
                    default:             op = ALU_NOP;
                endcase
            end
            ALUOP_ITYPE: begin
                // funct7 is immediate bits for addi, so only srai looks at it.
                if (f3 == F3_ADD) begin
                    op = ALU_ADD;
                end else if (f3 == F3_SRA && f7 == F7_ALT) begin
                    op = ALU_SRA;
                end
            end
            default: op = ALU_NOP;
        endcase
    end

    always_comb begin
        alu_res = 32'd0;
        case (op)
            ALU_ADD: alu_res = opa + opb;
            ALU_SUB: alu_res = opa - opb;
            ALU_AND: alu_res = opa & opb;
            ALU_XOR: alu_res = opa ^ opb;
            ALU_SLL: alu_res = opa << opb[4:0];
            ALU_SRA: alu_res = $signed(opa) >>> opb[4:0];
            default: alu_res = 32'd0;
        endcase
    end

    assign mul_start = !mul_busy && bus.valid_i && (op == ALU_MUL);

    mul_iter u_mul (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Gated by reset so a held mul on the inputs cannot raise stall while in reset.
    assign bus.stall_o = rst_i && (mul_start || (mul_busy && !mul_done));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            result_q <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
        end else if (mul_done) begin
            // Upstream held the mul instruction, so its control/rd/store data are still on the inputs.
            valid_q  <= 1'b1;
            ctrl_q   <= ctrl_in;
            result_q <= mul_product;
            wdata_q  <= bus.Readdata2_i;
            rd_q     <= bus.INS_11_7_i;
        end else if (!mul_busy && bus.valid_i && op != ALU_MUL) begin
            valid_q  <= 1'b1;
            ctrl_q   <= ctrl_in;
            result_q <= alu_res;
            wdata_q  <= bus.Readdata2_i;
            rd_q     <= bus.INS_11_7_i;
        end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.RegWrite_o  = ctrl_q.reg_write;
    assign bus.MemToReg_o  = ctrl_q.mem_to_reg;
    assign bus.MemRead_o   = ctrl_q.mem_read;
    assign bus.MemWrite_o  = ctrl_q.mem_write;
    assign bus.ALUResult_o = result_q;
    assign bus.MemWdata_o  = wdata_q;
    assign bus.RdAddr_o    = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expected EX/MEM records,
// a negedge monitor pops and compares whenever valid_o is high.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   cyc   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        int          due;
    } exp_t;

    exp_t sb[$];

    ex_stage_if bus();

    ex_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (bus.valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: actual valid_o 1 with result %h, required no output", bus.ALUResult_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", bus.ALUResult_o, e.res);
                check("mem_wdata", bus.MemWdata_o, e.wdata);
                check("rd_addr", {27'd0, bus.RdAddr_o}, {27'd0, e.rd});
                check("ctrl", {28'd0, bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o, bus.MemWrite_o},
                      {28'd0, e.ctrl});
                check("output_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // ctrl = {RegWrite, MemToReg, MemRead, MemWrite}
    task automatic set_in(input logic [1:0] aluop, input logic src, input logic [9:0] alu,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] rd, input logic [3:0] ctrl);
        bus.valid_i     = 1'b1;
        bus.ALUOp_i     = aluop;
        bus.ALUSrc_i    = src;
        bus.ALU_i       = alu;
        bus.Readdata1_i = a;
        bus.Readdata2_i = b;
        bus.Imm_i       = imm;
        bus.INS_11_7_i  = rd;
        {bus.RegWrite_i, bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i} = ctrl;
    endtask

    task automatic issue(input logic [1:0] aluop, input logic src, input logic [9:0] alu,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [3:0] ctrl, input logic [31:0] exp_res);
        exp_t e;
        set_in(aluop, src, alu, a, b, imm, rd, ctrl);
        e.res = exp_res; e.wdata = b; e.rd = rd; e.ctrl = ctrl; e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk_i); #1;
    endtask

    task automatic go_idle();
        bus.valid_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int abort_at);
        int   n = 0;
        int   start_cyc;
        logic bubbles_ok = 1'b1;
        logic aborted = 1'b0;
        exp_t e;
        set_in(ALUOP_RTYPE, 1'b0, {F7_MULDIV, F3_ADD}, a, b, 32'h0, rd, 4'b1000);
        start_cyc = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (bus.stall_o !== 1'b1) break;
            n++;
            if (n >= 2 && bus.valid_o !== 1'b0) bubbles_ok = 1'b0;
            if (n == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            rst_i = 1'b0;
            #1;
            check("rst_ctrl", {27'd0, bus.valid_o, bus.RegWrite_o, bus.MemToReg_o, bus.MemRead_o,
                  bus.MemWrite_o}, 32'd0);
            check("rst_result", bus.ALUResult_o, 32'd0);
            check("rst_wdata", bus.MemWdata_o, 32'd0);
            check("rst_rd", {27'd0, bus.RdAddr_o}, 32'd0);
            check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
            return;
        end
        check("mul_stall_cycles", 32'(n), 32'd32);
        check("mul_bubbles", {31'd0, bubbles_ok}, 32'd1);
        e.res = exp_res; e.wdata = b; e.rd = rd; e.ctrl = 4'b1000; e.due = start_cyc + 33;
        sb.push_back(e);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: actual simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.valid_i = 1'b0; bus.ALUOp_i = 2'b00; bus.ALUSrc_i = 1'b0; bus.ALU_i = 10'd0;
        bus.Readdata1_i = 32'd0; bus.Readdata2_i = 32'd0; bus.Imm_i = 32'd0; bus.INS_11_7_i = 5'd0;
        {bus.RegWrite_i, bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i} = 4'b0000;

        repeat (2) @(negedge clk_i);
        check("reset_valid", {31'd0, bus.valid_o}, 32'd0);
        check("reset_result", bus.ALUResult_o, 32'd0);
        check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Back-to-back single-cycle ops.
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_ADD}, 32'd5, 32'd7, 32'd0, 5'd1, 4'b1000, 32'd12);
        issue(ALUOP_RTYPE, 1'b0, {F7_ALT, F3_ADD}, 32'd5, 32'd7, 32'd0, 5'd2, 4'b1000, 32'hFFFF_FFFE);
        issue(ALUOP_ADD, 1'b1, 10'h3FF, 32'h100, 32'h1234, 32'hFFFF_FFFC, 5'd5, 4'b1110, 32'h0000_00FC);
        issue(ALUOP_ITYPE, 1'b1, {F7_ALT, F3_SRA}, 32'h8000_0010, 32'h0, 32'h0000_0404, 5'd6, 4'b1000,
              32'hF800_0001);
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_AND}, 32'hF0F0, 32'h0FF0, 32'd0, 5'd7, 4'b1000, 32'h00F0);
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_XOR}, 32'hFF00, 32'h0FF0, 32'd0, 5'd8, 4'b1000, 32'hF0F0);
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_SLL}, 32'd1, 32'h25, 32'd0, 5'd9, 4'b1000, 32'h20);
        issue(ALUOP_ITYPE, 1'b1, {7'h7F, F3_ADD}, 32'd10, 32'h55, 32'hFFFF_FFFD, 5'd10, 4'b1000, 32'd7);
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, 3'b010}, 32'd3, 32'd9, 32'd0, 5'd11, 4'b1000, 32'd0);
        issue(ALUOP_SUB, 1'b0, 10'd0, 32'd9, 32'd3, 32'd0, 5'd12, 4'b0000, 32'd6);
        issue(ALUOP_ADD, 1'b1, 10'd0, 32'h200, 32'hDEAD_BEEF, 32'd8, 5'd0, 4'b0001, 32'h208);

        // Bubble carrying write enables must not leak them.
        set_in(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_ADD}, 32'd1, 32'd1, 32'd0, 5'd13, 4'b1001);
        bus.valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("bubble_ctrl", {29'd0, bus.valid_o, bus.RegWrite_o, bus.MemWrite_o}, 32'd0);
        check("bubble_hold", bus.ALUResult_o, 32'h208);
        @(posedge clk_i); #1;

        do_mul(32'd7, 32'd6, 5'd3, 32'd42, -1);
        do_mul(32'hFFFF_FFFD, 32'd5, 5'd4, 32'hFFFF_FFF1, -1);
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_ADD}, 32'd100, 32'd23, 32'd0, 5'd14, 4'b1000, 32'd123);
        go_idle();
        repeat (2) @(posedge clk_i);
        #1;

        // Reset in the middle of a mul (12th stall cycle = cnt 10).
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_ADD}, 32'd1, 32'd2, 32'd0, 5'd15, 4'b1000, 32'd3);
        do_mul(32'd9, 32'd9, 5'd16, 32'd81, 12);
        check("sb_empty_at_reset", 32'(sb.size()), 32'd0);
        bus.valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_held_stall", {31'd0, bus.stall_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        issue(ALUOP_RTYPE, 1'b0, {F7_BASE, F3_ADD}, 32'd3, 32'd4, 32'd0, 5'd17, 4'b1000, 32'd7);
        go_idle();
        repeat (4) @(posedge clk_i);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
